// File: rtl/hs_sink_fifo.sv
// hs_sink_fifo -- destination-domain consumer for the async handshake CDC stage.
//
// Each single-cycle hs_valid pulse has its hs_data word stored in a small FIFO.
// A one-cycle hs_ack pulse is returned once the word is in storage. The stored
// words are presented downstream on a registered, first-word-fall-through
// valid/ready stream.
//
// Ports:
//   clk, rst_n        destination clock; asynchronous active-low reset
//   hs_data/hs_valid  incoming word and its one-cycle strobe
//   hs_ack            one-cycle pulse: word stored, the next one may be sent
//   m_data/m_valid    head-of-FIFO word (registered) and its valid flag
//   m_ready           downstream accepts m_data this cycle
//   count             words held in the FIFO (the pending register is not counted)
//   proto_err         sticky: hs_valid arrived while a word was still unacknowledged
//
// Optional feature (macro HS_SINK_STATS_EN):
//   words_rx      saturating count of words written into the FIFO
//   stall_cycles  saturating count of cycles spent in PEND
module hs_sink_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] hs_data,
    input  logic              hs_valid,
    output logic              hs_ack,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  count,
    output logic              proto_err
`ifdef HS_SINK_STATS_EN
    ,
    output logic [15:0]       words_rx,
    output logic [15:0]       stall_cycles
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ACK} state_t;

    state_t                        state_q, state_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [DATA_W-1:0]             pend_q, pend_d;
    logic [DATA_W-1:0]             m_data_q, m_data_d;
    logic                          m_valid_q, m_valid_d;
    logic                          ack_q, ack_d;
    logic                          perr_q, perr_d;

    logic                          pop, full, wr_en;
    logic [DATA_W-1:0]             wdata;

    assign pop  = m_valid_q && m_ready;
    assign full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        perr_d  = perr_q;
        wr_en   = 1'b0;
        wdata   = hs_data;
        unique case (state_q)
            ST_IDLE: begin
                if (hs_valid) begin
                    // A pop on this edge frees a slot, so a full FIFO can still accept.
                    if (!full || pop) begin
                        wr_en   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        pend_d  = hs_data;
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (hs_valid) perr_d = 1'b1;
                if (pop) begin
                    wr_en   = 1'b1;
                    wdata   = pend_q;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (hs_valid) perr_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ack_d = (state_d == ST_ACK);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d   = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        m_valid_d = (count_d != '0);
        // The next head is either already in storage or is the word being
        // written this edge (when the FIFO is left with only that word).
        m_data_d = m_data_q;
        if (count_d != '0)
            m_data_d = (wr_en && rd_ptr_d == wr_ptr_q) ? wdata : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            ack_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            ack_q     <= ack_d;
            perr_q    <= perr_d;
        end
    end

    assign hs_ack    = ack_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign count     = count_q;
    assign proto_err = perr_q;

`ifdef HS_SINK_STATS_EN
    logic [15:0] words_rx_q, words_rx_d, stall_q, stall_d;

    always_comb begin
        words_rx_d = words_rx_q;
        stall_d    = stall_q;
        if (wr_en && words_rx_q != 16'hFFFF) words_rx_d = words_rx_q + 16'd1;
        if (state_q == ST_PEND && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_rx_q <= '0;
            stall_q    <= '0;
        end else begin
            words_rx_q <= words_rx_d;
            stall_q    <= stall_d;
        end
    end

    assign words_rx     = words_rx_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hs_sink_fifo.sv
// Directed bench for hs_sink_fifo: a vector table for the main flow, plus
// hand-written sequences for full push/pop and reset while in PEND.
module tb_hs_sink_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hs_data = '0;
    logic       hs_valid = 1'b0;
    logic       hs_ack;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [2:0] count;
    logic       proto_err;
`ifdef HS_SINK_STATS_EN
    logic [15:0] words_rx, stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hs_sink_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .hs_data(hs_data), .hs_valid(hs_valid),
        .hs_ack(hs_ack), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .proto_err(proto_err)
`ifdef HS_SINK_STATS_EN
        , .words_rx(words_rx), .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       ack;
        logic       mv;
        logic [7:0] md;
        logic [2:0] cnt;
        logic       perr;
    } vec_t;

    vec_t vt[26];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge; sample 1 time unit after the next rising edge.
    task automatic step(input logic rn, input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        rst_n = rn; hs_valid = v; hs_data = d; m_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ack, input logic mv,
                           input logic [7:0] md, input logic [2:0] cnt, input logic perr);
        chk({tag, ".ack"},  16'(hs_ack),    16'(ack));
        chk({tag, ".mv"},   16'(m_valid),   16'(mv));
        chk({tag, ".md"},   16'(m_data),    16'(md));
        chk({tag, ".cnt"},  16'(count),     16'(cnt));
        chk({tag, ".perr"}, 16'(proto_err), 16'(perr));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Fill the FIFO with 01..04, checking each ack and its single-cycle width.
    task automatic fill4();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'(i + 1), 1'b0);
            chk($sformatf("fill%0d.ack", i), 16'(hs_ack), 16'd1);
            step(1'b1, 1'b0, 8'h00, 1'b0);
            chk($sformatf("fill%0d.ack_low", i), 16'(hs_ack), 16'd0);
        end
        chk("fill.cnt", 16'(count), 16'd4);
    endtask

    initial begin
        //           rst  v     d      r     ack   mv    md     cnt   perr
        vt[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b0};
        vt[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0};
        vt[11] = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0}; // full -> PEND
        vt[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0};
        vt[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 3'd4, 1'b0}; // pop 01, store 05
        vt[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd4, 1'b0};
        vt[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 3'd3, 1'b0};
        vt[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0};
        vt[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 3'd1, 1'b0};
        vt[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h05, 3'd0, 1'b0}; // drained, m_data holds
        vt[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 3'd0, 1'b0};
        vt[20] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0}; // wrapped pointers
        vt[21] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b1}; // hs_valid during ack
        vt[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b1};
        vt[23] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 3'd0, 1'b1}; // 22 was not stored
        vt[24] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vt[25] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};

        // Reset state
        #1;
        chk_out("reset", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
`ifdef HS_SINK_STATS_EN
        chk("reset.words_rx", words_rx, 16'd0);
        chk("reset.stall", stall_cycles, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(vt[i].rst_n, vt[i].v, vt[i].d, vt[i].r);
            chk_out($sformatf("vec%0d", i), vt[i].ack, vt[i].mv, vt[i].md, vt[i].cnt, vt[i].perr);
        end

        // Full FIFO with simultaneous push and pop
        do_reset();
        fill4();
        step(1'b1, 1'b1, 8'hAA, 1'b1);
        chk_out("fullpp", 1'b1, 1'b1, 8'h02, 3'd4, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk_out("fullpp.after", 1'b0, 1'b1, 8'h02, 3'd4, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk_out("fullpp.tail", 1'b0, 1'b1, 8'hAA, 3'd1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk_out("fullpp.empty", 1'b0, 1'b0, 8'hAA, 3'd0, 1'b0);

        // Reset while in PEND
        do_reset();
        fill4();
        step(1'b1, 1'b1, 8'h55, 1'b0);
        chk_out("pend", 1'b0, 1'b1, 8'h01, 3'd4, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
`ifdef HS_SINK_STATS_EN
        chk("pend.stall", stall_cycles, 16'd3);
        chk("pend.words_rx", words_rx, 16'd4);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_out("pend.rst", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
`ifdef HS_SINK_STATS_EN
        chk("pend.rst.stall", stall_cycles, 16'd0);
        chk("pend.rst.words_rx", words_rx, 16'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            chk_out($sformatf("pend.post%0d", i), 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
